// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I pipeline control: writeback select,
// forwarding select and the data-memory wait FSM states.
package riscv_pkg;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_LD  = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding select for one source operand.
// A match in MEM takes priority over a match in WB; x0 never forwards.
module forward_unit
  import riscv_pkg::*;
(
  input  logic [4:0] i_rs_addrE,
  input  logic [4:0] i_rd_addrM,
  input  logic [4:0] i_rd_addrW,
  input  logic       i_rd_wrenM,
  input  logic       i_rd_wrenW,
  output logic [1:0] o_fwd
);

  logic w_hitM;
  logic w_hitW;

  assign w_hitM = i_rd_wrenM && (i_rd_addrM != '0) && (i_rd_addrM == i_rs_addrE);
  assign w_hitW = i_rd_wrenW && (i_rd_addrW != '0) && (i_rd_addrW == i_rs_addrE);

  always_comb begin
    o_fwd = FWD_RF;
    if (w_hitM) begin
      o_fwd = FWD_M;
    end else if (w_hitW) begin
      o_fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline control for the five-stage RV32I core: stall/flush generation,
// EX forwarding selects and the multi-cycle data-memory wait tracker.
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_rs1_addrD,
  input  logic [4:0]  i_rs2_addrD,
  input  logic [4:0]  i_rs1_addrE,
  input  logic [4:0]  i_rs2_addrE,
  input  logic [4:0]  i_rd_addrE,
  input  logic [4:0]  i_rd_addrM,
  input  logic [4:0]  i_rd_addrW,
  input  logic        i_rd_wrenE,
  input  logic        i_rd_wrenM,
  input  logic        i_rd_wrenW,
  input  logic [1:0]  i_wb_selE,
  input  logic        i_pc_selE,
  input  logic        i_mem_reqM,
  input  logic        i_mem_ack,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        StallW,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        FlushW,
  output logic [1:0]  o_fwd_aE,
  output logic [1:0]  o_fwd_bE,
  output logic        o_mem_busy,
  output logic        o_mem_timeout,
  output logic [31:0] o_stall_cnt
);

  localparam int unsigned          WCNT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WCNT_W-1:0]    WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic [WCNT_W-1:0]   w_wait_cnt_nxt;
  logic                r_mem_timeout;
  logic [31:0]         r_stall_cnt;
  logic                w_timeout_now;
  logic                w_memwait;
  logic                w_branch;
  logic                w_load_use;
  logic [1:0]          w_fwd_a;
  logic [1:0]          w_fwd_b;

  forward_unit u_fwd_a (
    .i_rs_addrE (i_rs1_addrE),
    .i_rd_addrM (i_rd_addrM),
    .i_rd_addrW (i_rd_addrW),
    .i_rd_wrenM (i_rd_wrenM),
    .i_rd_wrenW (i_rd_wrenW),
    .o_fwd      (w_fwd_a)
  );

  forward_unit u_fwd_b (
    .i_rs_addrE (i_rs2_addrE),
    .i_rd_addrM (i_rd_addrM),
    .i_rd_addrW (i_rd_addrW),
    .i_rd_wrenM (i_rd_wrenM),
    .i_rd_wrenW (i_rd_wrenW),
    .o_fwd      (w_fwd_b)
  );

  // Forwarding is forced to the register file while reset is held.
  assign o_fwd_aE      = i_rst_n ? w_fwd_a : FWD_RF;
  assign o_fwd_bE      = i_rst_n ? w_fwd_b : FWD_RF;
  assign o_mem_busy    = (r_state == MEM_WAIT);
  assign o_mem_timeout = r_mem_timeout;
  assign o_stall_cnt   = r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    StallW = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;

    // On the timeout cycle the access is released as if acknowledged.
    w_timeout_now = (r_state == MEM_WAIT) && (r_wait_cnt == WCNT_LAST) && !i_mem_ack;
    w_memwait     = i_mem_reqM && !i_mem_ack && !w_timeout_now;
    w_branch      = i_pc_selE && !w_memwait;
    w_load_use    = (i_wb_selE == WB_LD) && i_rd_wrenE && (i_rd_addrE != '0) &&
                    ((i_rd_addrE == i_rs1_addrD) || (i_rd_addrE == i_rs2_addrD)) &&
                    !w_memwait && !i_pc_selE;

    if (i_rst_n) begin
      if (w_memwait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (w_branch) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (w_load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end

    unique case (r_state)
      RUN: begin
        if (w_memwait) begin
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (i_mem_ack || !i_mem_reqM || w_timeout_now) begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WCNT_W'(1);
        end
      end
      default: begin
        w_state_nxt    = RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      if (w_timeout_now) begin
        r_mem_timeout <= 1'b1;
      end
      if (StallF && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a cycle-level reference model predicts
// every output for each driven cycle; a negedge monitor compares.
module tb_hazard_unit;
  import riscv_pkg::*;

  localparam int unsigned TMO = 4;

  logic        i_clk;
  logic        i_rst_n;
  logic [4:0]  i_rs1_addrD, i_rs2_addrD, i_rs1_addrE, i_rs2_addrE;
  logic [4:0]  i_rd_addrE, i_rd_addrM, i_rd_addrW;
  logic        i_rd_wrenE, i_rd_wrenM, i_rd_wrenW;
  logic [1:0]  i_wb_selE;
  logic        i_pc_selE, i_mem_reqM, i_mem_ack;
  logic        StallF, StallD, StallE, StallM, StallW;
  logic        FlushD, FlushE, FlushM, FlushW;
  logic [1:0]  o_fwd_aE, o_fwd_bE;
  logic        o_mem_busy, o_mem_timeout;
  logic [31:0] o_stall_cnt;

  hazard_unit #(.MEM_TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rs1_addrD(i_rs1_addrD), .i_rs2_addrD(i_rs2_addrD),
    .i_rs1_addrE(i_rs1_addrE), .i_rs2_addrE(i_rs2_addrE),
    .i_rd_addrE(i_rd_addrE), .i_rd_addrM(i_rd_addrM), .i_rd_addrW(i_rd_addrW),
    .i_rd_wrenE(i_rd_wrenE), .i_rd_wrenM(i_rd_wrenM), .i_rd_wrenW(i_rd_wrenW),
    .i_wb_selE(i_wb_selE), .i_pc_selE(i_pc_selE),
    .i_mem_reqM(i_mem_reqM), .i_mem_ack(i_mem_ack),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .o_fwd_aE(o_fwd_aE), .o_fwd_bE(o_fwd_bE),
    .o_mem_busy(o_mem_busy), .o_mem_timeout(o_mem_timeout), .o_stall_cnt(o_stall_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    bit       rst_n;
    bit [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    bit       wrenE, wrenM, wrenW;
    bit [1:0] wbE;
    bit       pcsel, req, ack;
  } stim_t;

  typedef struct {
    bit [4:0]  stall;   // {F,D,E,M,W}
    bit [3:0]  flush;   // {D,E,M,W}
    bit [1:0]  fa, fb;
    bit        busy, tmo;
    bit [31:0] cnt;
    string     tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   end_req  = 0;
  bit   end_ack  = 0;

  // Reference model state: in a wait, cycles spent so far, sticky timeout, stall count.
  bit          m_wait;
  int unsigned m_wcnt;
  bit          m_tmo;
  longint unsigned m_cnt;

  function automatic bit [1:0] ref_fwd(bit [4:0] rs, bit [4:0] rdM, bit wM, bit [4:0] rdW, bit wW);
    if (wM && rdM != 0 && rdM == rs) return FWD_M;
    if (wW && rdW != 0 && rdW == rs) return FWD_W;
    return FWD_RF;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1'b1, wbE: WB_ALU, default: '0};
    return s;
  endfunction

  task automatic drive(input stim_t s, input string tag);
    exp_t e;
    bit   tn, mw, lu;
    @(posedge i_clk);
    #1;
    i_rst_n = s.rst_n;
    i_rs1_addrD = s.rs1D; i_rs2_addrD = s.rs2D;
    i_rs1_addrE = s.rs1E; i_rs2_addrE = s.rs2E;
    i_rd_addrE = s.rdE; i_rd_addrM = s.rdM; i_rd_addrW = s.rdW;
    i_rd_wrenE = s.wrenE; i_rd_wrenM = s.wrenM; i_rd_wrenW = s.wrenW;
    i_wb_selE = s.wbE; i_pc_selE = s.pcsel;
    i_mem_reqM = s.req; i_mem_ack = s.ack;

    e.tag = tag; e.stall = '0; e.flush = '0; e.fa = FWD_RF; e.fb = FWD_RF;
    if (!s.rst_n) begin
      m_wait = 0; m_wcnt = 0; m_tmo = 0; m_cnt = 0;
      e.busy = 0; e.tmo = 0; e.cnt = 0;
      sb.push_back(e);
      return;
    end
    tn = m_wait && (m_wcnt == TMO - 1) && !s.ack;
    mw = s.req && !s.ack && !tn;
    lu = (s.wbE == WB_LD) && s.wrenE && s.rdE != 0 && (s.rdE == s.rs1D || s.rdE == s.rs2D);
    if (mw) begin
      e.stall = 5'b11110; e.flush = 4'b0001;
    end else if (s.pcsel) begin
      e.flush = 4'b1100;
    end else if (lu) begin
      e.stall = 5'b11000; e.flush = 4'b0100;
    end
    e.fa   = ref_fwd(s.rs1E, s.rdM, s.wrenM, s.rdW, s.wrenW);
    e.fb   = ref_fwd(s.rs2E, s.rdM, s.wrenM, s.rdW, s.wrenW);
    e.busy = m_wait;
    e.tmo  = m_tmo;
    e.cnt  = 32'(m_cnt);
    sb.push_back(e);

    if (!m_wait) begin
      if (mw) begin m_wait = 1; m_wcnt = 1; end
    end else if (s.ack || !s.req || tn) begin
      m_wait = 0; m_wcnt = 0;
    end else begin
      m_wcnt++;
    end
    if (tn) m_tmo = 1;
    if (e.stall[4] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
  endtask

  task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %h expected %h at %0t", tag, name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall", e.tag, 32'({StallF, StallD, StallE, StallM, StallW}), 32'(e.stall));
        chk("flush", e.tag, 32'({FlushD, FlushE, FlushM, FlushW}), 32'(e.flush));
        chk("fwd_a", e.tag, 32'(o_fwd_aE), 32'(e.fa));
        chk("fwd_b", e.tag, 32'(o_fwd_bE), 32'(e.fb));
        chk("busy",  e.tag, 32'(o_mem_busy), 32'(e.busy));
        chk("tmo",   e.tag, 32'(o_mem_timeout), 32'(e.tmo));
        chk("cnt",   e.tag, o_stall_cnt, e.cnt);
      end
      if (end_req && !end_ack) begin
        chk("drain", "end", 32'(sb.size()), 32'd0);
        end_ack = 1;
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    i_rst_n = 1'b0;
    i_rs1_addrD = '0; i_rs2_addrD = '0; i_rs1_addrE = '0; i_rs2_addrE = '0;
    i_rd_addrE = '0; i_rd_addrM = '0; i_rd_addrW = '0;
    i_rd_wrenE = 0; i_rd_wrenM = 0; i_rd_wrenW = 0;
    i_wb_selE = WB_ALU; i_pc_selE = 0; i_mem_reqM = 0; i_mem_ack = 0;
    m_wait = 0; m_wcnt = 0; m_tmo = 0; m_cnt = 0;

    // Reset held with active-looking inputs: everything must stay quiet.
    s = idle(); s.rst_n = 0; s.req = 1; s.pcsel = 1;
    s.rdM = 5; s.wrenM = 1; s.rs1E = 5;
    repeat (2) drive(s, "reset");

    s = idle(); s.rdM = 5; s.rdW = 5; s.wrenM = 1; s.wrenW = 1; s.rs1E = 5; s.rs2E = 0;
    drive(s, "fwdM");
    s.wrenM = 0;
    drive(s, "fwdW");

    s = idle(); s.wbE = WB_LD; s.wrenE = 1; s.rdE = 7; s.rs2D = 7;
    drive(s, "loaduse");
    drive(idle(), "after_lu");

    s.pcsel = 1;
    drive(s, "br_lu");
    drive(idle(), "after_br");

    s = idle(); s.req = 1;
    repeat (3) drive(s, "wait3");
    s.ack = 1;
    drive(s, "wait3_ack");
    drive(idle(), "after_wait");

    s = idle(); s.req = 1;
    repeat (4) drive(s, "timeout");
    drive(idle(), "after_tmo");
    drive(idle(), "tmo_sticky");

    s = idle(); s.req = 1;
    repeat (2) drive(s, "req_drop");
    drive(idle(), "req_fell");
    drive(idle(), "req_fell2");

    s = idle(); s.req = 1;
    repeat (2) drive(s, "rst_wait");
    s.rst_n = 0;
    drive(s, "rst_mid");
    drive(idle(), "rst_rel");

    for (int i = 0; i < 600; i++) begin
      s.rst_n = ($urandom_range(0, 99) != 0);
      s.rs1D = 5'($urandom_range(0, 3)); s.rs2D = 5'($urandom_range(0, 3));
      s.rs1E = 5'($urandom_range(0, 3)); s.rs2E = 5'($urandom_range(0, 3));
      s.rdE  = 5'($urandom_range(0, 3)); s.rdM  = 5'($urandom_range(0, 3));
      s.rdW  = 5'($urandom_range(0, 3));
      s.wrenE = 1'($urandom); s.wrenM = 1'($urandom); s.wrenW = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       s.wbE = WB_ALU;
        1:       s.wbE = WB_LD;
        default: s.wbE = WB_PC4;
      endcase
      s.pcsel = ($urandom_range(0, 4) == 0);
      s.req   = ($urandom_range(0, 2) != 0);
      s.ack   = ($urandom_range(0, 5) == 0);
      drive(s, "random");
    end

    drive(idle(), "pre_sat");
    @(negedge i_clk);
    #1;
    force dut.r_stall_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.r_stall_cnt;
    m_cnt = 64'hFFFF_FFFD;
    s = idle(); s.wbE = WB_LD; s.wrenE = 1; s.rdE = 3; s.rs1D = 3;
    repeat (5) drive(s, "saturate");
    drive(idle(), "sat_hold");

    repeat (2) @(posedge i_clk);
    end_req = 1;
    for (int i = 0; i < 10 && !end_ack; i++) @(posedge i_clk);
    if (!end_ack) $display("FAIL end: monitor did not drain within bound");
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Central pipeline-control block for the five-stage RV32I core. It drives the stall and flush inputs of every pipeline register, including StallW/FlushW of the MEM/WB register. It selects EX-stage operand forwarding and tracks multi-cycle data-memory accesses with a wait FSM, a timeout, and a saturating stall-cycle counter. It sits beside the datapath: it reads register addresses and control bits from the D/E/M/W stages and returns control only.

## Interface
- MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before forced release (≥2)
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_rs1_addrD, i_rs2_addrD  in  5  source registers in decode
- i_rs1_addrE, i_rs2_addrE  in  5  source registers in execute
- i_rd_addrE, i_rd_addrM, i_rd_addrW  in  5  destination per stage
- i_rd_wrenE, i_rd_wrenM, i_rd_wrenW  in  1  destination write enable per stage
- i_wb_selE  in  2  writeback select in execute (WB_LD marks a load)
- i_pc_selE  in  1  branch/jump taken, resolved in execute
- i_mem_reqM  in  1  load/store access active in memory stage
- i_mem_ack  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM, StallW  out  1  hold stage register
- FlushD, FlushE, FlushM, FlushW  out  1  bubble stage register
- o_fwd_aE, o_fwd_bE  out  2  operand select: FWD_RF, FWD_W, FWD_M
- o_mem_busy  out  1  FSM in MEM_WAIT
- o_mem_timeout  out  1  sticky: a memory access was force-released
- o_stall_cnt  out  32  cycles in which StallF was asserted

## Operation
- Forwarding, per operand: FWD_M if i_rd_wrenM, rd_addrM≠0 and rd_addrM==rsE. Otherwise FWD_W if the same test passes for W. Otherwise FWD_RF. M has priority over W.
- Memory wait (memwait): i_mem_reqM && !i_mem_ack && !timeout_now. Drives StallF..StallM=1, StallW=0, FlushW=1 (bubble into W while M holds), all other Flush=0. Highest priority; suppresses branch and load-use actions.
- Branch: i_pc_selE=1 and no memwait drives FlushD=1, FlushE=1. Load-use is ignored that cycle.
- Load-use: i_wb_selE==WB_LD, i_rd_wrenE, rd_addrE≠0 and rd_addrE equals rs1D or rs2D, with no memwait and no branch. Drives StallF=StallD=1, FlushE=1.
- Otherwise all Stall/Flush are 0.
- FSM states:
  - RUN: goes to MEM_WAIT when memwait; wait counter loads 1.
  - MEM_WAIT: returns to RUN on i_mem_ack, on !i_mem_reqM, or on timeout_now. Otherwise the wait counter increments.
  - timeout_now = state==MEM_WAIT && wait counter==MEM_TIMEOUT-1 && !i_mem_ack. On that cycle the access is treated as acknowledged: no stall, M advances, and o_mem_timeout sets. It stays set until reset.
- A zero-wait access (req and ack in the same cycle) never leaves RUN and never stalls.
- o_stall_cnt increments on every cycle with StallF=1 and saturates at 32'hFFFF_FFFF.

## Timing
- Stall, flush and forwarding outputs are combinational from the inputs, state and wait counter. The pipeline registers act on them at the next rising edge.
- Load-use costs exactly 1 bubble.
- Branch costs 2 squashed instructions.
- A memory access with N wait cycles holds F..M for N cycles and injects N W-bubbles.
- Reset state:
  - State RUN, wait counter 0, o_mem_busy=0, o_mem_timeout=0, o_stall_cnt=0.
  - While i_rst_n=0, all Stall/Flush=0 and fwd=FWD_RF.
  - Reset during MEM_WAIT aborts the wait immediately.
- o_mem_busy is registered: high from the cycle after memwait is entered through the ack cycle.
- Simultaneous ack and timeout count: ack wins, o_mem_timeout does not set.
- i_mem_reqM falling while in MEM_WAIT returns the FSM to RUN with no timeout.

## Structure
- riscv_pkg holds:
  - WB_ALU=2'd0, WB_LD=2'd1, WB_PC4=2'd2
  - FWD_RF=2'd0, FWD_W=2'd1, FWD_M=2'd2
  - state enum {RUN, MEM_WAIT}
- Sub-module forward_unit (combinational, instantiated once per operand) computes one fwd select.
- The FSM, counters and priority logic live in hazard_unit.

## Test plan
- Forwarding: rd_addrM=5, rd_addrW=5, both wren=1, rs1E=5, rs2E=0 -> o_fwd_aE=FWD_M, o_fwd_bE=FWD_RF. Clearing i_rd_wrenM -> o_fwd_aE=FWD_W.
- Load-use: i_wb_selE=WB_LD, rd_addrE=7, rs2D=7 for 1 cycle -> StallF=StallD=FlushE=1 that cycle, o_stall_cnt=1 after.
- Branch plus load-use on the same cycle -> FlushD=FlushE=1, StallF=StallD=0.
- Wait: i_mem_reqM=1, ack after 3 cycles -> Stall F..M and FlushW high for 3 cycles. o_mem_busy high 3 cycles starting 1 later. o_stall_cnt=3.
- Timeout with MEM_TIMEOUT=4: req held and ack never -> 3 stall cycles, release on the 4th cycle, o_mem_timeout=1 sticky. Asserting i_rst_n=0 mid-wait -> all outputs return to reset values asynchronously.
- Saturation: force o_stall_cnt near max via a long stall -> holds at 32'hFFFF_FFFF.
